// File: rtl/e_mdu_if.sv
// ---------------------------------------------------------------------------
// e_mdu_if : request/result bundle between the E stage and the multiply/divide
// unit.
//   start  request qualifier; op/A/B are sampled when start=1 at a rising edge
//   op     000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//          110/111 no-op
//   A, B   operands (rs, rt)
//   busy   a mult/div is in flight
//   done   one-cycle pulse when HI/LO first show a new mult/div result
//   hi, lo architectural HI/LO registers
// master : the E-stage side that issues requests.
// slave  : the multiply/divide unit.
// ---------------------------------------------------------------------------
interface e_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : multi-cycle multiply/divide unit for the E stage.
// Owns the HI/LO registers. mult/multu/div/divu complete after a fixed
// latency (MULT_CYCLES / DIV_CYCLES edges); mthi/mtlo write in one edge.
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   mdu    e_mdu_if slave port (start/op/A/B in; busy/done/hi/lo out)
// The result is computed combinationally at acceptance and parked in a
// pending register; a down-counter models the latency and commits the
// pending value to HI/LO on its final edge. HI/LO therefore keep the old
// result while busy, and a reset during RUN simply drops the pending value.
// ---------------------------------------------------------------------------
module e_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   mdu
);

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rhi_q, rhi_d;   // pending result, committed when cnt hits 1
  logic [WIDTH-1:0] rlo_q, rlo_d;
  logic             done_q, done_d;

  // ---------------------------------------------------------------------
  // Operation decode
  // ---------------------------------------------------------------------
  logic is_mult, is_div, is_sgn;

  always_comb begin
    is_mult = (mdu.op == 3'b000) || (mdu.op == 3'b001);
    is_div  = (mdu.op == 3'b010) || (mdu.op == 3'b011);
    is_sgn  = ~mdu.op[0];
  end

  // ---------------------------------------------------------------------
  // Datapath: both mult and div run on magnitudes, signs are fixed up
  // afterwards. For the most-negative operand the magnitude is the same bit
  // pattern read as unsigned, so most-negative / -1 falls out as
  // quotient = most-negative, remainder = 0 without a special case.
  // ---------------------------------------------------------------------
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_u, prod;
  logic [WIDTH-1:0]   quo_u, rem_u, quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    a_neg  = is_sgn & mdu.A[WIDTH-1];
    b_neg  = is_sgn & mdu.B[WIDTH-1];
    a_mag  = a_neg ? (~mdu.A + 1'b1) : mdu.A;
    b_mag  = b_neg ? (~mdu.B + 1'b1) : mdu.B;

    prod_u = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    prod   = (a_neg ^ b_neg) ? (~prod_u + 1'b1) : prod_u;

    // Divider guarded so a zero divisor never reaches the operator.
    quo_u  = '0;
    rem_u  = '0;
    if (b_mag != '0) begin
      quo_u = a_mag / b_mag;
      rem_u = a_mag % b_mag;
    end
    quo    = (a_neg ^ b_neg) ? (~quo_u + 1'b1) : quo_u;
    rem    = a_neg ? (~rem_u + 1'b1) : rem_u;

    if (is_mult) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (mdu.B == '0) begin
      // Divide by zero: dividend into HI, all ones into LO, no trap.
      res_hi = mdu.A;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. Any start seen in RUN is dropped, mthi/mtlo included,
  // so a misbehaving issue stage cannot tear the HI/LO pair.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mdu.start) begin
          if (is_mult || is_div) begin
            state_d = S_RUN;
            cnt_d   = is_mult ? MULT_N : DIV_N;
            rhi_d   = res_hi;
            rlo_d   = res_lo;
          end else if (mdu.op == 3'b100) begin
            hi_d = mdu.A;
          end else if (mdu.op == 3'b101) begin
            lo_d = mdu.A;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          hi_d    = rhi_q;
          lo_d    = rlo_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    mdu.busy = (state_q == S_RUN);
    mdu.done = done_q;
    mdu.hi   = hi_q;
    mdu.lo   = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  e_mdu_if #(.WIDTH(W)) bus ();

  e_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  res_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   n_exp    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected HI/LO pair.
  always @(negedge clk) begin
    res_t e;
    if (reset && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("done_hi", 64'(bus.hi), 64'(e.hi));
        chk("done_lo", 64'(bus.lo), 64'(e.lo));
      end
    end
  end

  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    res_t        res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      3'd0: begin p = sa * sb; res.hi = p[63:32]; res.lo = p[31:0]; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; res.hi = up[63:32]; res.lo = up[31:0]; end
      3'd2: begin
        if (b == 0) begin res.hi = a; res.lo = '1; end
        else begin q = sa / sb; r = sa % sb; res.hi = r[31:0]; res.lo = q[31:0]; end
      end
      default: begin
        if (b == 0) begin res.hi = a; res.lo = '1; end
        else begin res.hi = a % b; res.lo = a / b; end
      end
    endcase
    return res;
  endfunction

  // Issue one mult/div, check HI/LO hold while busy and the busy length.
  task automatic run_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input int lat);
    logic [W-1:0] oh, ol;
    int cyc;
    exp_q.push_back({eh, el});
    n_exp++;
    @(negedge clk);
    oh = bus.hi; ol = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    chk("hold_hi", 64'(bus.hi), 64'(oh));
    chk("hold_lo", 64'(bus.lo), 64'(ol));
    cyc = 0;
    while (bus.busy && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_len", 64'(cyc), 64'(lat));
  endtask

  // Single-cycle move / no-op: value visible next cycle, busy/done stay low.
  task automatic mv(input logic [2:0] op, input logic [W-1:0] a,
                    input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = 32'h5555_5555;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mv_hi", 64'(bus.hi), 64'(eh));
    chk("mv_lo", 64'(bus.lo), 64'(el));
    chk("mv_busy", 64'(bus.busy), 64'd0);
    chk("mv_done", 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    res_t         e;
    int           cyc, dc0;

    bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    reset = 1'b1;

    run_md(3'd0, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC);
    run_md(3'd1, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA, MC);
    run_md(3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
    run_md(3'd3, 32'h7,         32'h2, 32'h1,         32'h3,         DC);
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DC);
    run_md(3'd3, 32'h1234,      32'h0, 32'h1234,      32'hFFFF_FFFF, DC);
    run_md(3'd2, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, DC);

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 3 == 1 && op[1]) b = -b;
      e  = model(op, a, b);
      run_md(op, a, b, e.hi, e.lo, op[1] ? DC : MC);
    end

    mv(3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, bus.lo);
    mv(3'd5, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);
    mv(3'd6, 32'hCAFE_0000, 32'hDEAD_BEEF, 32'h1234_5678);
    mv(3'd7, 32'hCAFE_0001, 32'hDEAD_BEEF, 32'h1234_5678);

    // Requests while busy are dropped.
    exp_q.push_back({32'h0, 32'd12});
    n_exp++;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    cyc = 0;
    while (bus.busy && cyc < 300) begin
      case (cyc)
        0:       begin bus.op = 3'd3; bus.A = 32'd9; bus.B = 32'd0; end
        1:       begin bus.op = 3'd4; bus.A = 32'hAAAA; end
        default: bus.start = 1'b0;
      endcase
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("busy_len_ign", 64'(cyc), 64'(MC));
    @(negedge clk);
    chk("ign_hi", 64'(bus.hi), 64'd0);
    chk("ign_lo", 64'(bus.lo), 64'd12);
    chk("ign_busy", 64'(bus.busy), 64'd0);

    // Reset mid-flight abandons the divide.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_hi", 64'(bus.hi), 64'd0);
    chk("mid_rst_lo", 64'(bus.lo), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    dc0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("no_late_done", 64'(done_cnt), 64'(dc0));
    chk("late_lo", 64'(bus.lo), 64'd0);
    chk("late_busy", 64'(bus.busy), 64'd0);

    chk("done_count", 64'(done_cnt), 64'(n_exp));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit for the E stage. Sits beside the combinational ALU.
- Owns the architectural HI/LO registers.
- Executes mult/multu/div/divu with a fixed, parametrised latency, plus single-cycle mthi/mtlo writes.
- Exposes busy so the hazard unit stalls any MD-class instruction in D while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MULT_CYCLES, 5, clock edges from an accepted mult/multu to HI/LO update; legal range 1 to 255.
- DIV_CYCLES, 10, clock edges from an accepted div/divu to HI/LO update; legal range 1 to 255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request qualifier; op/A/B are sampled when start=1 at a rising edge.
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op.
- A  input  WIDTH  operand rs (dividend, multiplicand, mthi/mtlo source).
- B  input  WIDTH  operand rt (divisor, multiplier).
- busy  output  1  high while a mult/div is in flight.
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new mult/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0 at an edge):
  - hi=0, lo=0, busy=0, done=0, counter=0, state=IDLE.
  - Any in-flight operation is abandoned and its result is never written.
- States: IDLE, RUN.
- IDLE, start=1, op in {000..011}, at edge T:
  - Latch op, A, B.
  - Load the counter with MULT_CYCLES (ops 000/001) or DIV_CYCLES (ops 010/011).
  - Go to RUN; busy=1 from after edge T.
- RUN:
  - Counter decrements each edge.
  - At edge T+N (N = the loaded latency), hi/lo are written, busy returns to 0, done=1 for one cycle, state returns to IDLE.
  - busy is therefore high for exactly N cycles.
- Back-to-back: a new start is accepted at edge T+N+1 at the earliest (busy is already 0 in the preceding cycle).
- IDLE, start=1, op=100: hi<=A at the next edge. op=101: lo<=A at the next edge. busy and done stay 0.
- start while busy=1: ignored for every op, including mthi/mtlo. The hazard unit guarantees this never happens legitimately; the block must still not corrupt state.
- op 110/111 with start=1: no state change.
- Results:
  - mult: {hi,lo} = signed(A)*signed(B), full 2*WIDTH product.
  - multu: {hi,lo} = unsigned product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed overflow case (most-negative / -1): lo = most-negative value, hi = 0.
- Divide by zero (B=0, div or divu):
  - Full latency still applies.
  - Result is hi=A, lo=all ones; no exception is raised.
- Implementation choice is free: compute at acceptance and hold, or iterate. Externally visible timing must match the above exactly.
- hi/lo hold their old values throughout RUN, so reads during busy return the previous result.

Test Plan:
1. Reset; mult with A=0xFFFFFFFE, B=0x00000003 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
2. multu with A=0xFFFFFFFE, B=3 -> hi=0x00000002, lo=0xFFFFFFFA after 5 cycles. Then div with A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. divu with A=7, B=2 -> lo=3, hi=1. Then div with A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0. Then divu with A=0x1234, B=0 -> hi=0x1234, lo=0xFFFFFFFF after 10 cycles.
4. mthi A=0xDEADBEEF -> hi=0xDEADBEEF the next cycle, busy stays 0. Then mtlo A=0x12345678 -> lo updated the next cycle.
5. Start mult(3,4), then assert start with divu(9,0) and mthi(0xAAAA) during busy -> both ignored; hi=0, lo=12 at completion; busy timing unchanged.
6. Start div(100,7); drive reset=0 for one edge at cycle 4 -> hi=lo=0, busy=0 the next cycle. After release, no late write and done stays 0 for 20 cycles.
